// File: rtl/apb_plic_multiword.sv
// APB3 RISC-V PLIC with multi-word enable/pending/trigger banks, per-source
// programmable level/edge gateways with a one-deep deferred edge, registered target notification.
module apb_plic_multiword #(
  parameter int N_SOURCE = 64,
  parameter int N_TARGET = 2,
  parameter int MAX_PRIO = 7,
  parameter int PRIOW    = $clog2(MAX_PRIO + 1),
  parameter int SRCW     = $clog2(N_SOURCE + 1),
  parameter int NWORD    = (N_SOURCE + 32) / 32
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [31:0]         paddr_i,
  input  logic                psel_i,
  input  logic                penable_i,
  input  logic                pwrite_i,
  input  logic [31:0]         pwdata_i,
  output logic [31:0]         prdata_o,
  output logic                pready_o,
  output logic                pslverr_o,
  input  logic [N_SOURCE-1:0] irq_sources_i,
  output logic [N_TARGET-1:0] eip_targets_o
);

  localparam int NBIT = NWORD * 32;

  function automatic logic [NBIT-1:0] src_mask();
    logic [NBIT-1:0] m;
    m = '0;
    for (int i = 1; i <= N_SOURCE; i++) m[i] = 1'b1;
    return m;
  endfunction

  // Bank bits that map to a real source: bit 0 (ID 0) and bits above N_SOURCE are never stored.
  localparam logic [NBIT-1:0] VMASK = src_mask();

  logic [PRIOW-1:0]    prio_q     [N_SOURCE+1];
  logic [PRIOW-1:0]    prio_d     [N_SOURCE+1];
  logic [NBIT-1:0]     pend_q, pend_d, infl_q, infl_d;
  logic [NBIT-1:0]     defer_q, defer_d, trig_q, trig_d;
  logic [NBIT-1:0]     en_q       [N_TARGET];
  logic [NBIT-1:0]     en_d       [N_TARGET];
  logic [PRIOW-1:0]    thr_q      [N_TARGET];
  logic [PRIOW-1:0]    thr_d      [N_TARGET];
  logic [SRCW-1:0]     claim_id_q [N_TARGET];
  logic [SRCW-1:0]     claim_id_d [N_TARGET];
  logic [N_TARGET-1:0] eip_q, eip_d;
  logic [N_SOURCE-1:0] src_q, src_d;

  logic [23:0]      addr;
  logic             unused_paddr;
  logic             in_prio, in_pend, in_trig, in_en, is_thr, is_claim;
  int               s_idx, w_idx, et_idx, ew_idx, tt_idx;
  logic             hit, access, wr_ok, rd_ok;
  logic [PRIOW-1:0] wsat;
  logic [NBIT-1:0]  src_ext, srcq_ext, rise, busy;
  logic [31:0]      rdata;

  assign addr         = paddr_i[25:2];
  assign unused_paddr = ^{paddr_i[31:26], paddr_i[1:0]};

  always_comb begin
    in_prio  = (addr[23:10] == 14'd0);
    in_pend  = (addr[23:9] == 15'd2);
    in_trig  = (addr[23:9] == 15'd3);
    in_en    = (addr[23:9] == 15'd4);
    is_thr   = (addr[23:19] == 5'd1) && (addr[9:0] == 10'd0);
    is_claim = (addr[23:19] == 5'd1) && (addr[9:0] == 10'd1);
    s_idx    = int'(addr[9:0]);
    w_idx    = int'(addr[8:0]);
    et_idx   = int'(addr[8:5]);
    ew_idx   = int'(addr[4:0]);
    tt_idx   = int'(addr[18:10]);
    hit      = (in_prio && s_idx <= N_SOURCE) ||
               (in_pend && w_idx < NWORD && !pwrite_i) ||
               (in_trig && w_idx < NWORD) ||
               (in_en && et_idx < N_TARGET && ew_idx < NWORD) ||
               ((is_thr || is_claim) && tt_idx < N_TARGET);
    access   = psel_i && penable_i;
    wr_ok    = access && pwrite_i && hit;
    rd_ok    = access && !pwrite_i && hit;
    wsat     = (pwdata_i > 32'(MAX_PRIO)) ? PRIOW'(MAX_PRIO) : pwdata_i[PRIOW-1:0];
  end

  always_comb begin
    rdata = '0;
    if (access && hit) begin
      if (in_prio) begin
        for (int i = 0; i <= N_SOURCE; i++)
          if (s_idx == i) rdata = 32'(prio_q[i]);
      end else if (in_pend || in_trig) begin
        for (int k = 0; k < NWORD; k++)
          if (w_idx == k) rdata = in_pend ? pend_q[k*32 +: 32] : trig_q[k*32 +: 32];
      end else if (in_en) begin
        for (int t = 0; t < N_TARGET; t++)
          for (int k = 0; k < NWORD; k++)
            if (et_idx == t && ew_idx == k) rdata = en_q[t][k*32 +: 32];
      end else begin
        for (int t = 0; t < N_TARGET; t++)
          if (tt_idx == t) rdata = is_thr ? 32'(thr_q[t]) : 32'(claim_id_q[t]);
      end
    end
  end

  assign prdata_o      = rdata;
  assign pready_o      = access;
  assign pslverr_o     = access && !hit && !rst_i;
  assign eip_targets_o = eip_q;

  // Gateways first, then claim/complete, then register writes; claim overrides a same-edge set.
  always_comb begin
    src_d    = irq_sources_i;
    src_ext  = NBIT'({irq_sources_i, 1'b0});
    srcq_ext = NBIT'({src_q, 1'b0});
    rise     = src_ext & ~srcq_ext;
    busy     = pend_q | infl_q;
    pend_d   = pend_q | (VMASK & ~busy & ((~trig_q & src_ext) | (trig_q & rise)));
    defer_d  = defer_q | (VMASK & trig_q & rise & busy);
    infl_d   = infl_q;
    trig_d   = trig_q;
    prio_d   = prio_q;
    en_d     = en_q;
    thr_d    = thr_q;

    for (int t = 0; t < N_TARGET; t++) begin
      for (int i = 1; i <= N_SOURCE; i++) begin
        if (rd_ok && is_claim && tt_idx == t && int'(claim_id_q[t]) == i && pend_q[i]) begin
          pend_d[i] = 1'b0;
          infl_d[i] = 1'b1;
        end
        if (wr_ok && is_claim && tt_idx == t && pwdata_i == 32'(i) && infl_q[i] && en_q[t][i]) begin
          infl_d[i] = 1'b0;
          if (defer_d[i]) begin
            pend_d[i]  = 1'b1;
            defer_d[i] = 1'b0;
          end
        end
      end
    end

    for (int k = 0; k < NWORD; k++) begin
      if (wr_ok && in_trig && w_idx == k) begin
        trig_d[k*32 +: 32]  = pwdata_i & VMASK[k*32 +: 32];
        defer_d[k*32 +: 32] = '0;
      end
      for (int t = 0; t < N_TARGET; t++)
        if (wr_ok && in_en && et_idx == t && ew_idx == k)
          en_d[t][k*32 +: 32] = pwdata_i & VMASK[k*32 +: 32];
    end

    for (int i = 1; i <= N_SOURCE; i++)
      if (wr_ok && in_prio && s_idx == i) prio_d[i] = wsat;
    for (int t = 0; t < N_TARGET; t++)
      if (wr_ok && is_thr && tt_idx == t) thr_d[t] = wsat;
  end

  // Strictly-greater compare while scanning upward gives ties to the lowest ID.
  always_comb begin
    logic [PRIOW-1:0] best_p;
    logic [SRCW-1:0]  best_id;
    eip_d = '0;
    for (int t = 0; t < N_TARGET; t++) begin
      best_p  = thr_q[t];
      best_id = '0;
      for (int i = 1; i <= N_SOURCE; i++) begin
        if (pend_q[i] && en_q[t][i] && prio_q[i] > best_p) begin
          best_p  = prio_q[i];
          best_id = SRCW'(i);
        end
      end
      claim_id_d[t] = best_id;
      eip_d[t]      = (best_id != '0);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      prio_q     <= '{default: '0};
      pend_q     <= '0;
      infl_q     <= '0;
      defer_q    <= '0;
      trig_q     <= '0;
      en_q       <= '{default: '0};
      thr_q      <= '{default: '0};
      claim_id_q <= '{default: '0};
      eip_q      <= '0;
      src_q      <= '0;
    end else begin
      prio_q     <= prio_d;
      pend_q     <= pend_d;
      infl_q     <= infl_d;
      defer_q    <= defer_d;
      trig_q     <= trig_d;
      en_q       <= en_d;
      thr_q      <= thr_d;
      claim_id_q <= claim_id_d;
      eip_q      <= eip_d;
      src_q      <= src_d;
    end
  end

endmodule

// File: tb/tb_apb_plic_multiword.sv
// Directed bench for apb_plic_multiword: register-map vector table plus hand-written
// gateway, claim/complete and arbitration sequences on the default 64-source, 2-target build.
module tb_apb_plic_multiword;

  localparam int N_SOURCE = 64;
  localparam int N_TARGET = 2;

  logic                clk_i = 1'b0;
  logic                rst_i;
  logic [31:0]         paddr_i;
  logic                psel_i;
  logic                penable_i;
  logic                pwrite_i;
  logic [31:0]         pwdata_i;
  logic [31:0]         prdata_o;
  logic                pready_o;
  logic                pslverr_o;
  logic [N_SOURCE-1:0] irq_sources_i;
  logic [N_TARGET-1:0] eip_targets_o;

  int n_compared   = 0;
  int n_mismatched = 0;

  apb_plic_multiword dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .paddr_i       (paddr_i),
    .psel_i        (psel_i),
    .penable_i     (penable_i),
    .pwrite_i      (pwrite_i),
    .pwdata_i      (pwdata_i),
    .prdata_o      (prdata_o),
    .pready_o      (pready_o),
    .pslverr_o     (pslverr_o),
    .irq_sources_i (irq_sources_i),
    .eip_targets_o (eip_targets_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [31:0] exp_rd, input logic exp_err);
    vec_t v;
    v.wr = wr; v.addr = addr; v.wdata = wdata; v.exp_rd = exp_rd; v.exp_err = exp_err;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // One full APB transfer starting at a negedge: setup, access, idle.
  task automatic applyStimulus(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                               output logic [31:0] rdata, output logic err);
    psel_i = 1'b1; penable_i = 1'b0; pwrite_i = wr; paddr_i = addr; pwdata_i = wdata;
    @(negedge clk_i);
    penable_i = 1'b1;
    #1;
    rdata = prdata_o;
    err   = pslverr_o;
    checkOutput($sformatf("pready @0x%08h", addr), 32'(pready_o), 32'h1);
    @(negedge clk_i);
    psel_i = 1'b0; penable_i = 1'b0; pwrite_i = 1'b0;
  endtask

  task automatic rd_chk(input string name, input logic [31:0] addr, input logic [31:0] exp);
    logic [31:0] d;
    logic        e;
    applyStimulus(1'b0, addr, 32'h0, d, e);
    checkOutput({name, " rdata"}, d, exp);
    checkOutput({name, " pslverr"}, 32'(e), 32'h0);
  endtask

  task automatic wr_chk(input string name, input logic [31:0] addr, input logic [31:0] data);
    logic [31:0] d;
    logic        e;
    applyStimulus(1'b1, addr, data, d, e);
    checkOutput({name, " pslverr"}, 32'(e), 32'h0);
  endtask

  task automatic eip_chk(input string name, input logic [N_TARGET-1:0] exp);
    checkOutput(name, 32'(eip_targets_o), 32'(exp));
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  task automatic pulse(input logic [N_SOURCE-1:0] m);
    irq_sources_i = irq_sources_i | m;
    cycles(1);
    irq_sources_i = irq_sources_i & ~m;
  endtask

  initial begin
    logic [31:0] d;
    logic        e;

    rst_i = 1'b1; psel_i = 1'b0; penable_i = 1'b0; pwrite_i = 1'b0;
    paddr_i = '0; pwdata_i = '0; irq_sources_i = '0;
    cycles(3);
    rst_i = 1'b0;
    cycles(1);
    eip_chk("reset eip", 2'b00);
    checkOutput("idle pready", 32'(pready_o), 32'h0);
    checkOutput("idle pslverr", 32'(pslverr_o), 32'h0);

    vecs.push_back(mk(1'b0, 32'h0000_0004, 32'h0, 32'h0, 1'b0));
    vecs.push_back(mk(1'b0, 32'h0000_2000, 32'h0, 32'h0, 1'b0));
    vecs.push_back(mk(1'b0, 32'h0020_0000, 32'h0, 32'h0, 1'b0));
    vecs.push_back(mk(1'b0, 32'h0020_0004, 32'h0, 32'h0, 1'b0));
    vecs.push_back(mk(1'b0, 32'h03FF_FFFC, 32'h0, 32'h0, 1'b1));
    vecs.push_back(mk(1'b1, 32'h0000_0004, 32'h9, 32'h0, 1'b0));
    vecs.push_back(mk(1'b0, 32'h0000_0004, 32'h0, 32'h7, 1'b0));
    vecs.push_back(mk(1'b0, 32'hFC00_0004, 32'h0, 32'h7, 1'b0));
    vecs.push_back(mk(1'b1, 32'h0000_0004, 32'h0, 32'h0, 1'b0));
    vecs.push_back(mk(1'b1, 32'h0000_0000, 32'h5, 32'h0, 1'b0));
    vecs.push_back(mk(1'b0, 32'h0000_0000, 32'h0, 32'h0, 1'b0));
    vecs.push_back(mk(1'b0, 32'h0000_0104, 32'h0, 32'h0, 1'b1));
    vecs.push_back(mk(1'b0, 32'h0000_0100, 32'h0, 32'h0, 1'b0));
    vecs.push_back(mk(1'b1, 32'h0000_1800, 32'hFFFF_FFFF, 32'h0, 1'b0));
    vecs.push_back(mk(1'b0, 32'h0000_1800, 32'h0, 32'hFFFF_FFFE, 1'b0));
    vecs.push_back(mk(1'b1, 32'h0000_1808, 32'hFFFF_FFFF, 32'h0, 1'b0));
    vecs.push_back(mk(1'b0, 32'h0000_1808, 32'h0, 32'h1, 1'b0));
    vecs.push_back(mk(1'b1, 32'h0000_1800, 32'h0, 32'h0, 1'b0));
    vecs.push_back(mk(1'b1, 32'h0000_1808, 32'h0, 32'h0, 1'b0));
    vecs.push_back(mk(1'b1, 32'h0000_2000, 32'hFFFF_FFFF, 32'h0, 1'b0));
    vecs.push_back(mk(1'b0, 32'h0000_2000, 32'h0, 32'hFFFF_FFFE, 1'b0));
    vecs.push_back(mk(1'b1, 32'h0000_2000, 32'h0, 32'h0, 1'b0));
    vecs.push_back(mk(1'b0, 32'h0000_100C, 32'h0, 32'h0, 1'b1));
    vecs.push_back(mk(1'b1, 32'h0000_1000, 32'h1, 32'h0, 1'b1));
    vecs.push_back(mk(1'b0, 32'h0000_1000, 32'h0, 32'h0, 1'b0));
    vecs.push_back(mk(1'b0, 32'h0000_208C, 32'h0, 32'h0, 1'b1));
    vecs.push_back(mk(1'b0, 32'h0000_2100, 32'h0, 32'h0, 1'b1));
    vecs.push_back(mk(1'b0, 32'h0020_2000, 32'h0, 32'h0, 1'b1));
    vecs.push_back(mk(1'b1, 32'h0020_0000, 32'd12, 32'h0, 1'b0));
    vecs.push_back(mk(1'b0, 32'h0020_0000, 32'h0, 32'h7, 1'b0));
    vecs.push_back(mk(1'b1, 32'h0020_0000, 32'h0, 32'h0, 1'b0));

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].wr, vecs[i].addr, vecs[i].wdata, d, e);
      if (!vecs[i].wr) checkOutput($sformatf("vec%0d rdata", i), d, vecs[i].exp_rd);
      checkOutput($sformatf("vec%0d pslverr", i), 32'(e), 32'(vecs[i].exp_err));
    end

    // Level source 40 routed to target 1.
    wr_chk("prio40", 32'h0000_00A0, 32'd5);
    wr_chk("en t1 w1", 32'h0000_2084, 32'h100);
    wr_chk("thr t1", 32'h0020_1000, 32'd2);
    irq_sources_i[39] = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    irq_sources_i[39] = 1'b0;
    eip_chk("eip40 not yet", 2'b00);
    cycles(1);
    eip_chk("eip40 rises", 2'b10);
    rd_chk("pend w1", 32'h0000_1004, 32'h100);
    irq_sources_i[39] = 1'b1;
    rd_chk("claim40", 32'h0020_1004, 32'd40);
    cycles(1);
    eip_chk("eip40 dropped", 2'b00);
    cycles(2);
    rd_chk("pend w1 inflight", 32'h0000_1004, 32'h0);
    wr_chk("complete40", 32'h0020_1004, 32'd40);
    cycles(1);
    eip_chk("eip40 after complete +1", 2'b00);
    cycles(1);
    eip_chk("eip40 re-raised", 2'b10);
    irq_sources_i[39] = 1'b0;
    rd_chk("claim40 again", 32'h0020_1004, 32'd40);
    wr_chk("complete40 again", 32'h0020_1004, 32'd40);
    cycles(3);
    eip_chk("eip40 idle", 2'b00);
    rd_chk("claim t1 empty", 32'h0020_1004, 32'd0);

    // Edge source 3 on target 0: extra edges while inflight collapse into one.
    wr_chk("trig w0", 32'h0000_1800, 32'h8);
    wr_chk("prio3", 32'h0000_000C, 32'd3);
    wr_chk("en t0 w0", 32'h0000_2000, 32'h8);
    pulse(64'h4);
    cycles(2);
    eip_chk("eip3", 2'b01);
    rd_chk("claim3", 32'h0020_0004, 32'd3);
    pulse(64'h4);
    cycles(1);
    pulse(64'h4);
    cycles(1);
    rd_chk("pend3 deferred", 32'h0000_1000, 32'h0);
    wr_chk("complete3", 32'h0020_0004, 32'd3);
    rd_chk("pend3 from deferred", 32'h0000_1000, 32'h8);
    rd_chk("claim3 second", 32'h0020_0004, 32'd3);
    wr_chk("complete3 second", 32'h0020_0004, 32'd3);
    cycles(3);
    eip_chk("eip3 idle", 2'b00);
    rd_chk("pend3 empty", 32'h0000_1000, 32'h0);
    rd_chk("claim3 none", 32'h0020_0004, 32'd0);

    // Sources 5 and 9: tie order, priority override, threshold masking.
    wr_chk("prio5", 32'h0000_0014, 32'd4);
    wr_chk("prio9", 32'h0000_0024, 32'd4);
    wr_chk("en t0 5/9", 32'h0000_2000, 32'h228);
    pulse(64'h110);
    cycles(2);
    rd_chk("pend 5/9", 32'h0000_1000, 32'h220);
    rd_chk("tie claim5", 32'h0020_0004, 32'd5);
    rd_chk("tie claim9", 32'h0020_0004, 32'd9);
    wr_chk("complete5", 32'h0020_0004, 32'd5);
    wr_chk("complete9", 32'h0020_0004, 32'd9);
    wr_chk("prio9 hi", 32'h0000_0024, 32'd7);
    pulse(64'h110);
    cycles(2);
    rd_chk("prio claim9", 32'h0020_0004, 32'd9);
    rd_chk("prio claim5", 32'h0020_0004, 32'd5);
    wr_chk("complete9 b", 32'h0020_0004, 32'd9);
    wr_chk("complete5 b", 32'h0020_0004, 32'd5);
    wr_chk("thr t0 7", 32'h0020_0000, 32'd7);
    pulse(64'h110);
    cycles(3);
    eip_chk("eip masked by thr", 2'b00);
    rd_chk("claim masked", 32'h0020_0004, 32'd0);
    rd_chk("pend after null claim", 32'h0000_1000, 32'h220);
    wr_chk("thr t0 0", 32'h0020_0000, 32'd0);
    eip_chk("eip thr release +0", 2'b00);
    cycles(1);
    eip_chk("eip thr released", 2'b01);
    rd_chk("claim9 c", 32'h0020_0004, 32'd9);
    irq_sources_i[8] = 1'b1;
    cycles(2);
    wr_chk("complete9 wrong tgt", 32'h0020_1004, 32'd9);
    cycles(3);
    rd_chk("pend inflight kept", 32'h0000_1000, 32'h20);
    wr_chk("complete9 c", 32'h0020_0004, 32'd9);
    rd_chk("pend 9 resampled", 32'h0000_1000, 32'h220);
    irq_sources_i[8] = 1'b0;

    // Reset with live state clears everything.
    rst_i = 1'b1;
    cycles(2);
    rst_i = 1'b0;
    eip_chk("eip after reset", 2'b00);
    rd_chk("prio9 after reset", 32'h0000_0024, 32'h0);
    rd_chk("pend after reset", 32'h0000_1000, 32'h0);
    rd_chk("en after reset", 32'h0000_2000, 32'h0);
    rd_chk("trig after reset", 32'h0000_1800, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
